// File: rtl/vram_access_scheduler_if.sv
// Bundles the raster, scanout-read, write-request and RAM-port signals of the VRAM scheduler.
// The scheduler takes the slave view; the source of timing, reads and writes takes the master view.
interface vram_access_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              video_on;
    logic [31:0]       pixel_y;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              vblank_start;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  video_on, pixel_y, rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata, vblank_start, fifo_count
    );

    modport master (
        output video_on, pixel_y, rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata, vblank_start, fifo_count
    );
endinterface

// File: rtl/vram_access_scheduler.sv
// Arbitrates the single display-RAM port: scanout reads always win, queued writes drain only
// inside blanking windows so a visible frame is never torn.
module vram_access_scheduler #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int V_DISPLAY    = 1080,
    parameter bit WR_IN_HBLANK = 1'b1
) (
    input logic                  clk_148_5MHz,
    input logic                  reset_n,
    vram_access_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_line;
    logic              vblank_start;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              push;
    logic              pop;
    logic              window_open;

    // Writes are refused while held in reset so nothing is queued that the flush would then drop.
    assign bus.wr_ready = reset_n && (count < CNT_W'(DEPTH));
    assign push         = bus.wr_valid && bus.wr_ready;
    assign window_open  = !bus.video_on &&
                          (state == VBLANK || (state == HBLANK && WR_IN_HBLANK));
    assign pop          = !bus.rd_req && window_open && (count != '0);

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            SYNC:           if (bus.video_on)  state_next = ACTIVE;
            ACTIVE:         if (!bus.video_on) state_next = last_line ? VBLANK : HBLANK;
            HBLANK, VBLANK: if (bus.video_on)  state_next = ACTIVE;
            default:        state_next = SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_148_5MHz) begin
        if (!reset_n) begin
            state        <= SYNC;
            last_line    <= 1'b0;
            vblank_start <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state        <= state_next;
            vblank_start <= (state_next == VBLANK) && (state != VBLANK);
            if (state == ACTIVE && bus.video_on)
                last_line <= (bus.pixel_y == 32'(V_DISPLAY - 1));

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Reads pre-empt writes; an idle cycle keeps the bus address and data stable.
            mem_en <= bus.rd_req || pop;
            mem_we <= pop;
            if (bus.rd_req) begin
                mem_addr <= bus.rd_addr;
            end else if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end
        end
    end

    // NOTE: queue storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_148_5MHz) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.vblank_start = vblank_start;
    assign bus.fifo_count   = count;
endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler: one instance drains in any blanking, a second
// instance only in vertical blanking; both share timing, reset and read stimulus.
module tb_vram_access_scheduler;
    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          video_on;
    logic [31:0]   pixel_y;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_valid_a;
    logic          wr_valid_b;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt_a = 0;
    int we_cnt_b = 0;
    int vbs_cnt_b = 0;

    always #5 clk = ~clk;

    vram_access_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) ia ();
    vram_access_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) ib ();

    assign ia.video_on = video_on;
    assign ia.pixel_y  = pixel_y;
    assign ia.rd_req   = rd_req;
    assign ia.rd_addr  = rd_addr;
    assign ia.wr_valid = wr_valid_a;
    assign ia.wr_addr  = wr_addr;
    assign ia.wr_data  = wr_data;
    assign ib.video_on = video_on;
    assign ib.pixel_y  = pixel_y;
    assign ib.rd_req   = rd_req;
    assign ib.rd_addr  = rd_addr;
    assign ib.wr_valid = wr_valid_b;
    assign ib.wr_addr  = wr_addr;
    assign ib.wr_data  = wr_data;

    vram_access_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .V_DISPLAY(1080), .WR_IN_HBLANK(1'b1)
    ) ua (
        .clk_148_5MHz(clk),
        .reset_n     (reset_n),
        .bus         (ia.slave)
    );

    vram_access_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .V_DISPLAY(1080), .WR_IN_HBLANK(1'b0)
    ) ub (
        .clk_148_5MHz(clk),
        .reset_n     (reset_n),
        .bus         (ib.slave)
    );

    always @(negedge clk) begin
        if (ia.mem_we === 1'b1)       we_cnt_a++;
        if (ib.mem_we === 1'b1)       we_cnt_b++;
        if (ib.vblank_start === 1'b1) vbs_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_valid_a = 1'b0;
        wr_valid_b = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int base_we;
        int base_vbs;
        int acc;
        bit exp_we;

        // 1: reset state, then no writes before the first video_on rise
        reset_n    = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_valid_a = 1'b0;
        wr_valid_b = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        step();
        step();
        #1;
        check("rst_mem_en",   32'(ia.mem_en), 32'd0);
        check("rst_mem_we",   32'(ia.mem_we), 32'd0);
        check("rst_addr",     32'(ia.mem_addr), 32'd0);
        check("rst_vbs",      32'(ia.vblank_start), 32'd0);
        check("rst_count",    32'(ia.fifo_count), 32'd0);
        check("rst_wr_ready", 32'(ia.wr_ready), 32'd0);
        check("rst_state",    32'(ua.state), 32'd0);
        reset_n = 1'b1;
        base_we = we_cnt_a;
        for (int i = 0; i < 3; i++) begin
            wr_valid_a = 1'b1;
            wr_addr    = AW'(32'h10 + i);
            wr_data    = DW'(i);
            step();
        end
        wr_valid_a = 1'b0;
        repeat (5) step();
        #1;
        check("sync_count",   32'(ia.fifo_count), 32'd3);
        check("sync_no_we",   32'(we_cnt_a - base_we), 32'd0);
        check("sync_state",   32'(ua.state), 32'd0);
        video_on = 1'b1;
        step();
        #1;
        check("sync_to_active", 32'(ua.state), 32'd1);
        check("sync_to_active_we", 32'(ia.mem_we), 32'd0);

        // 2: hblank drain, first write two cycles after video_on falls
        do_reset();
        video_on = 1'b1;
        pixel_y  = 32'd5;
        for (int i = 0; i < 4; i++) begin
            wr_valid_a = 1'b1;
            wr_addr    = AW'(32'h100 + i);
            wr_data    = DW'(8'hA0 + i);
            step();
        end
        wr_valid_a = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        #1;
        check("hb_T_we",    32'(ia.mem_we), 32'd0);
        check("hb_T_count", 32'(ia.fifo_count), 32'd4);
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            exp_we = (k >= 2 && k <= 5);
            check($sformatf("hb_we_T+%0d", k), 32'(ia.mem_we), 32'(exp_we));
            if (exp_we) begin
                check($sformatf("hb_addr_T+%0d", k), 32'(ia.mem_addr), 32'h100 + 32'(k - 2));
                check($sformatf("hb_data_T+%0d", k), 32'(ia.mem_wdata), 32'hA0 + 32'(k - 2));
            end
        end
        check("hb_count_end", 32'(ia.fifo_count), 32'd0);

        // 3: vblank-only drain across a full 1080-line frame
        do_reset();
        base_we  = we_cnt_b;
        base_vbs = vbs_cnt_b;
        for (int y = 0; y < 1080; y++) begin
            video_on = 1'b1;
            pixel_y  = 32'(y);
            for (int c = 0; c < 4; c++) begin
                wr_valid_b = (y == 10);
                wr_addr    = AW'(32'h200 + c);
                wr_data    = DW'(8'h50 + c);
                step();
            end
            wr_valid_b = 1'b0;
            if (y != 1079) begin
                video_on = 1'b0;
                pixel_y  = 32'd0;
                repeat (3) step();
            end
        end
        video_on = 1'b0;
        pixel_y  = 32'd0;
        #1;
        check("vb_no_we_frame", 32'(we_cnt_b - base_we), 32'd0);
        check("vb_count_held",  32'(ib.fifo_count), 32'd4);
        check("vb_no_pulse_yet", 32'(vbs_cnt_b - base_vbs), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            exp_we = (k >= 2 && k <= 5);
            check($sformatf("vb_pulse_T+%0d", k), 32'(ib.vblank_start), 32'(k == 1));
            check($sformatf("vb_we_T+%0d", k), 32'(ib.mem_we), 32'(exp_we));
            if (exp_we)
                check($sformatf("vb_addr_T+%0d", k), 32'(ib.mem_addr), 32'h200 + 32'(k - 2));
        end
        check("vb_pulse_once", 32'(vbs_cnt_b - base_vbs), 32'd1);
        check("vb_we_total",   32'(we_cnt_b - base_we), 32'd4);

        // 4: fill to DEPTH during active video, first pop re-opens wr_ready
        do_reset();
        video_on   = 1'b1;
        pixel_y    = 32'd5;
        wr_valid_a = 1'b1;
        acc        = 0;
        for (int i = 0; i < 20; i++) begin
            wr_addr = AW'(32'h300 + i);
            wr_data = DW'(i);
            #1;
            if (ia.wr_ready) acc++;
            step();
        end
        wr_valid_a = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        #1;
        check("full_accepted", 32'(acc), 32'd16);
        check("full_ready",    32'(ia.wr_ready), 32'd0);
        check("full_count",    32'(ia.fifo_count), 32'd16);
        step();
        #1;
        check("full_T+1_ready", 32'(ia.wr_ready), 32'd0);
        check("full_T+1_we",    32'(ia.mem_we), 32'd0);
        step();
        #1;
        check("full_T+2_we",    32'(ia.mem_we), 32'd1);
        check("full_T+2_addr",  32'(ia.mem_addr), 32'h300);
        check("full_T+2_count", 32'(ia.fifo_count), 32'd15);
        check("full_T+2_ready", 32'(ia.wr_ready), 32'd1);

        // 5: reads pre-empt pending writes inside vblank
        do_reset();
        video_on = 1'b1;
        pixel_y  = 32'd1079;
        for (int i = 0; i < 3; i++) begin
            wr_valid_a = (i < 2);
            wr_addr    = AW'(32'h400 + i);
            wr_data    = DW'(8'h70 + i);
            step();
        end
        wr_valid_a = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        for (int k = 1; k <= 7; k++) begin
            step();
            rd_req  = (k <= 3);
            rd_addr = AW'(32'h1F000 + k);
            #1;
            if (k == 1) begin
                check("rd_vbs",   32'(ia.vblank_start), 32'd1);
                check("rd_en_T+1", 32'(ia.mem_en), 32'd0);
            end else if (k <= 4) begin
                check($sformatf("rd_en_T+%0d", k),   32'(ia.mem_en), 32'd1);
                check($sformatf("rd_we_T+%0d", k),   32'(ia.mem_we), 32'd0);
                check($sformatf("rd_addr_T+%0d", k), 32'(ia.mem_addr), 32'h1F000 + 32'(k - 1));
            end else if (k <= 6) begin
                check($sformatf("rd_wen_T+%0d", k),  32'(ia.mem_en), 32'd1);
                check($sformatf("rd_wwe_T+%0d", k),  32'(ia.mem_we), 32'd1);
                check($sformatf("rd_waddr_T+%0d", k), 32'(ia.mem_addr), 32'h400 + 32'(k - 5));
                check($sformatf("rd_wdata_T+%0d", k), 32'(ia.mem_wdata), 32'h70 + 32'(k - 5));
            end else begin
                check("rd_idle_T+7", 32'(ia.mem_en), 32'd0);
            end
        end
        rd_req = 1'b0;

        // 6: reset mid-drain discards the 5 pending writes
        do_reset();
        video_on = 1'b1;
        pixel_y  = 32'd5;
        for (int i = 0; i < 8; i++) begin
            wr_valid_a = 1'b1;
            wr_addr    = AW'(32'h500 + i);
            wr_data    = DW'(i);
            step();
        end
        wr_valid_a = 1'b0;
        video_on   = 1'b0;
        pixel_y    = 32'd0;
        repeat (4) step();
        #1;
        check("mid_count",  32'(ia.fifo_count), 32'd5);
        check("mid_we",     32'(ia.mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ia.wr_ready), 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        check("mid_rst_en",    32'(ia.mem_en), 32'd0);
        check("mid_rst_count", 32'(ia.fifo_count), 32'd0);
        check("mid_rst_state", 32'(ua.state), 32'd0);
        step();
        #1;
        check("post_rst_en",    32'(ia.mem_en), 32'd0);
        check("post_rst_count", 32'(ia.fifo_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
